// File: rtl/sim_run_controller.sv
// Run sequencer: steps the simulator core through IDLE -> WARMUP -> MEASURE -> DRAIN
// and gates core stepping, traffic injection and statistics collection.
module sim_run_controller #(
    parameter int unsigned MaxCycleWidth = 5,
    parameter int unsigned DrainTimeout  = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [MaxCycleWidth-1:0] warmup_cycles_i,
    input  logic [MaxCycleWidth-1:0] measure_cycles_i,
    input  logic                     core_idle_i,
    output logic [1:0]               state_o,
    output logic [MaxCycleWidth-1:0] current_cycle_o,
    output logic                     core_enable_o,
    output logic                     inject_enable_o,
    output logic                     stats_enable_o,
    output logic                     done_o,
    output logic                     timeout_o
);

    localparam int unsigned Mcw = MaxCycleWidth;
    localparam int unsigned Dw  = (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;
    localparam logic [Dw-1:0]  DrainLast = Dw'(DrainTimeout - 1);
    localparam logic [Mcw-1:0] One       = Mcw'(1);
    localparam logic [Mcw-1:0] Zero      = '0;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWarmup  = 2'd1,
        StMeasure = 2'd2,
        StDrain   = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [Mcw-1:0] cycle_q, cycle_d;
    logic [Mcw-1:0] phase_q, phase_d;
    logic [Dw-1:0]  drain_q, drain_d;
    logic [Mcw-1:0] warm_q, warm_d;
    logic [Mcw-1:0] meas_q, meas_d;
    logic           done_q, done_d;
    logic           timeout_q, timeout_d;
    logic           core_en_q, core_en_d;
    logic           inject_en_q, inject_en_d;
    logic           stats_en_q, stats_en_d;
    logic           phase_last;

    // Latched budgets are always >= 1 while their phase is active, so limit-1 never wraps.
    assign phase_last = (state_q == StWarmup) ? (phase_q == warm_q - One)
                                              : (phase_q == meas_q - One);

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        phase_d   = phase_q;
        drain_d   = drain_q;
        warm_d    = warm_q;
        meas_d    = meas_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    warm_d    = warmup_cycles_i;
                    meas_d    = (measure_cycles_i == Zero) ? One : measure_cycles_i;
                    cycle_d   = '0;
                    phase_d   = '0;
                    drain_d   = '0;
                    timeout_d = 1'b0;
                    state_d   = (warmup_cycles_i == Zero) ? StMeasure : StWarmup;
                end
            end
            StWarmup, StMeasure: begin
                cycle_d = cycle_q + One;
                if (abort_i) begin
                    state_d = StDrain;
                    phase_d = '0;
                    drain_d = '0;
                end else if (phase_last) begin
                    state_d = (state_q == StWarmup) ? StMeasure : StDrain;
                    phase_d = '0;
                    drain_d = '0;
                end else begin
                    phase_d = phase_q + One;
                end
            end
            StDrain: begin
                cycle_d = cycle_q + One;
                if (core_idle_i) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (drain_q == DrainLast) begin
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    drain_d = drain_q + Dw'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        core_en_d   = (state_d != StIdle);
        inject_en_d = (state_d == StWarmup) || (state_d == StMeasure);
        stats_en_d  = (state_d == StMeasure);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cycle_q     <= '0;
            phase_q     <= '0;
            drain_q     <= '0;
            warm_q      <= '0;
            meas_q      <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            core_en_q   <= 1'b0;
            inject_en_q <= 1'b0;
            stats_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_q     <= cycle_d;
            phase_q     <= phase_d;
            drain_q     <= drain_d;
            warm_q      <= warm_d;
            meas_q      <= meas_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            core_en_q   <= core_en_d;
            inject_en_q <= inject_en_d;
            stats_en_q  <= stats_en_d;
        end
    end

    assign state_o         = state_q;
    assign current_cycle_o = cycle_q;
    assign core_enable_o   = core_en_q;
    assign inject_enable_o = inject_en_q;
    assign stats_enable_o  = stats_en_q;
    assign done_o          = done_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Bench for sim_run_controller: each run's full phase schedule is planned up front from the
// budgets, abort point and core_idle pattern, then compared cycle by cycle.
module tb_sim_run_controller;

    localparam int Mcw = 5;
    localparam int Dto = 16;
    localparam int NoAbort = 1000;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           start_i;
    logic           abort_i;
    logic [Mcw-1:0] warmup_cycles_i;
    logic [Mcw-1:0] measure_cycles_i;
    logic           core_idle_i;
    logic [1:0]     state_o;
    logic [Mcw-1:0] current_cycle_o;
    logic           core_enable_o;
    logic           inject_enable_o;
    logic           stats_enable_o;
    logic           done_o;
    logic           timeout_o;

    int n_pass  = 0;
    int n_total = 0;
    int last_cc = 0;
    logic last_to = 1'b0;

    sim_run_controller #(
        .MaxCycleWidth(Mcw),
        .DrainTimeout (Dto)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .warmup_cycles_i (warmup_cycles_i),
        .measure_cycles_i(measure_cycles_i),
        .core_idle_i     (core_idle_i),
        .state_o         (state_o),
        .current_cycle_o (current_cycle_o),
        .core_enable_o   (core_enable_o),
        .inject_enable_o (inject_enable_o),
        .stats_enable_o  (stats_enable_o),
        .done_o          (done_o),
        .timeout_o       (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Expected enables follow directly from the phase: core in any run phase, injection in
    // WARMUP/MEASURE, statistics only in MEASURE.
    task automatic chk(input string tag, input int st, input int cc, input logic dn,
                       input logic to);
        logic [11:0] got, exp;
        logic [Mcw-1:0] ccv;
        logic [1:0] stv;
        ccv = Mcw'(cc % 32);
        stv = 2'(st);
        exp = {stv, ccv, (st != 0), (st == 1 || st == 2), (st == 2), dn, to};
        got = {state_o, current_cycle_o, core_enable_o, inject_enable_o, stats_enable_o,
               done_o, timeout_o};
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got st=%0d cc=%0d en=%b done=%b to=%b, want st=%0d cc=%0d en=%b done=%b to=%b",
                    tag, got[11:10], got[9:5], got[4:2], got[1], got[0],
                    exp[11:10], exp[9:5], exp[4:2], exp[1], exp[0]);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            start_i          = 1'b0;
            abort_i          = 1'($urandom_range(0, 1));
            core_idle_i      = 1'($urandom_range(0, 1));
            warmup_cycles_i  = Mcw'($urandom);
            measure_cycles_i = Mcw'($urandom);
            tick();
            chk("idle_hold", 0, last_cc, 1'b0, last_to);
        end
    endtask

    // idle_mode: 0 never idle, 1 always idle, 2 idle only on the last DRAIN slot, 3 random.
    task automatic run(input string tag, input int w, input int m, input int a,
                       input int idle_mode, input int gap);
        logic idle [0:127];
        int meff, ds, len, total, st;
        logic to;
        meff = (m == 0) ? 1 : m;
        ds   = (a < w + meff) ? a + 1 : w + meff;
        for (int k = 0; k < 128; k++) begin
            case (idle_mode)
                0:       idle[k] = 1'b0;
                1:       idle[k] = 1'b1;
                2:       idle[k] = (k == ds + Dto - 1);
                default: idle[k] = ($urandom_range(0, 3) == 0);
            endcase
        end
        len = Dto;
        to  = 1'b1;
        for (int d = 0; d < Dto; d++) begin
            if (idle[ds + d]) begin
                len = d + 1;
                to  = 1'b0;
                break;
            end
        end
        total = ds + len;

        warmup_cycles_i  = Mcw'(w);
        measure_cycles_i = Mcw'(m);
        start_i          = 1'b1;
        abort_i          = 1'b0;
        tick();
        for (int k = 0; k < total; k++) begin
            st = (k >= ds) ? 3 : (k < w) ? 1 : 2;
            chk(tag, st, k, 1'b0, 1'b0);
            core_idle_i      = idle[k];
            abort_i          = (k == a) || (k >= ds && $urandom_range(0, 1) == 1);
            start_i          = 1'($urandom_range(0, 1));
            warmup_cycles_i  = Mcw'($urandom);
            measure_cycles_i = Mcw'($urandom);
            tick();
        end
        last_cc = total;
        last_to = to;
        chk({tag, "_done"}, 0, total, 1'b1, to);
        idle_gap(gap);
    endtask

    initial begin
        reset_i          = 1'b1;
        start_i          = 1'b0;
        abort_i          = 1'b0;
        core_idle_i      = 1'b0;
        warmup_cycles_i  = '0;
        measure_cycles_i = '0;
        tick();
        tick();
        chk("reset", 0, 0, 1'b0, 1'b0);
        start_i = 1'b1;
        tick();
        chk("reset_hold", 0, 0, 1'b0, 1'b0);
        reset_i = 1'b0;
        start_i = 1'b0;
        tick();
        idle_gap(2);

        run("basic_3_4", 3, 4, NoAbort, 1, 2);
        run("skip_warmup", 0, 0, NoAbort, 1, 2);
        run("drain_timeout", 2, 3, NoAbort, 0, 3);
        run("wrap_20_20", 20, 20, NoAbort, 1, 2);
        run("abort_measure", 2, 10, 3, 1, 2);
        run("abort_warmup", 5, 4, 0, 3, 1);
        run("idle_at_limit", 1, 2, NoAbort, 2, 2);
        run("abort_at_end", 2, 3, 4, 1, 1);

        for (int r = 0; r < 24; r++) begin
            int a;
            a = ($urandom_range(0, 2) == 0) ? NoAbort : int'($urandom_range(0, 30));
            run("random", int'($urandom_range(0, 14)), int'($urandom_range(0, 14)), a,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of MEASURE: outputs return to reset values, no done pulse.
        run("pre_reset", 1, 1, NoAbort, 0, 1);
        warmup_cycles_i  = Mcw'(2);
        measure_cycles_i = Mcw'(10);
        start_i          = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("mid_run", (k < 2) ? 1 : 2, k, 1'b0, 1'b0);
            core_idle_i = 1'b1;
            tick();
        end
        reset_i = 1'b1;
        tick();
        chk("reset_mid", 0, 0, 1'b0, 1'b0);
        reset_i = 1'b0;
        last_cc = 0;
        last_to = 1'b0;
        idle_gap(4);
        run("after_reset", 1, 2, NoAbort, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
